sram_1r1w_model: RTL
====================

# sram_1r1w_model

Behavioural model of a parametrised two-port (one read, one write) foundry SRAM macro for simulation builds of cache data and tag arrays. It is the next generation of the single-port models. It adds:
- independent read and write ports;
- a per-bit write mask;
- a selectable 1- or 2-cycle read latency;
- defined same-address collision behaviour;
- an asynchronous active-low reset of the output path.

Memory contents are never reset. Only the read pipeline and status outputs are.

## Interface
- Bits, 80, data word width.
- Word_Depth, 256, number of words; may be below 2^Add_Width.
- Add_Width, 8, address width.
- Read_Latency, 1, cycles from read request to QA; legal values 1 or 2 only.
- CLK  input  1  single clock; all sampling on the rising edge.
- RSTB  input  1  reset, asynchronous assert, active-low. Clears the output path only.
- CEBA  input  1  read-port chip enable, active-low.
- AA  input  Add_Width  read address.
- CEBB  input  1  write-port chip enable, active-low.
- AB  input  Add_Width  write address.
- DB  input  Bits  write data.
- BWEB  input  Bits  per-bit write enable, active-low (0 = bit is written).
- QA  output  Bits  read data; registered.
- COLL  output  1  pulses high in the same cycle as the QA of a read that collided with a write to the same address.

## Operation
- **Write.** With CEBB=0 at the edge and AB < Word_Depth, the stored word becomes (old & BWEB) | (DB & ~BWEB). With BWEB all ones, the word is unchanged.
- **Read.** With CEBA=0 at the edge and AA < Word_Depth, ram[AA] is captured. After Read_Latency edges it appears on QA.
- **Collision.** CEBA=0 and CEBB=0 in the same cycle with AA == AB. The read returns the pre-write word (read-before-write). COLL is asserted alongside that QA.
- **Out-of-range address.**
  - Write: ignored; the memory array is unchanged.
  - Read: treated as a non-read cycle for QA. COLL is 0.
- **Non-read cycle.** Applies when CEBA=1 or the address is out of range. QA behaviour is set by the macro (see Configuration).
- **Reset.**
  - RSTB low immediately forces QA=0 and COLL=0, and clears all pipeline stages and their valid flags.
  - Writes that occur while RSTB is low still update memory.
  - A read issued during reset is discarded.
- **Reset mid-pipeline.** With Read_Latency=2, reset between the request edge and the delivery edge discards the in-flight read. QA stays 0 until the first new read is delivered.

## Timing
- **Latency 1.** Read request at edge N; QA and COLL are valid after edge N, and hold until edge N+1.
- **Latency 2.** Request at edge N, internal stage at N, output at N+1. Back-to-back reads sustain one read per cycle.
- **Independent ports.** Write at edge N, read of the same address at edge N+1: the read returns the new data.
- **Reset values.** QA = {Bits{1'b0}}, COLL = 0.
- **Reset release.** On the first edge after RSTB rises, requests are accepted.

## Configuration
- The macro is SRAM_MODEL_RANDOM_OUT_EN.
- **Defined.** On any non-read cycle after reset, QA is loaded with pseudo-random data: concatenated $random words, truncated to Bits. Downstream logic that consumes QA without a valid read is therefore exposed. Collision data is still the pre-write word.
- **Undefined.** QA holds its last value on non-read cycles. This gives deterministic waveforms for regression diffing.
- Reset behaviour is identical in both builds.

## Structure
- **Shared package sram_model_pkg:**
  - SRAM_LAT_MIN=1 and SRAM_LAT_MAX=2;
  - a helper function that applies a bit mask to (old, new, mask);
  - an elaboration-time parameter check that raises a fatal error if Read_Latency is outside 1..2 or Word_Depth > 2^Add_Width.
- **Sub-module sram_rd_pipe.** Holds the per-stage data, valid and coll registers. It implements the Read_Latency stages, the non-read QA policy and the reset clearing.
- The top level holds the array, the write-mask logic and collision detection.

## Test plan
- **Reset.** Hold RSTB=0 for 3 cycles with CEBA=0, AA=0 -> QA=0 and COLL=0 throughout. The first read after release returns ram[0] with the configured latency.
- **Masked write.** Write 0xFF..FF to address 5, then write DB=0 with BWEB=0xFF..FF00 (low 8 bits enabled). Read address 5 -> 0xFF..FF00.
- **Collision.** Address 9 holds 0x1234; write 0xABCD to it and read it in the same cycle -> QA=0x1234 with COLL=1. The next-cycle read returns 0xABCD with COLL=0.
- **Latency 2 streaming.** Read addresses 0..7 back-to-back -> data for address k appears exactly 2 edges after its request, with no gaps or reordering. Reset asserted after the request for address 3 -> that read and later in-flight reads are dropped, and QA=0.
- **Out of range.** With Word_Depth=200, write to 250, then read 250 and read 199 -> memory unchanged. QA follows the non-read policy for 250 and returns the correct word for 199.
- **Macro check.** Idle after one read of 0x55. Without the macro -> QA holds 0x55. With the macro -> QA changes on idle cycles and COLL=0.

Source files
------------

// File: rtl/sram_model_pkg.sv
// Shared constants and helpers for the SRAM behavioural models.
// Holds the legal read-latency range, the bitwise write-mask merge and the parameter sanity check.
package sram_model_pkg;

  localparam int SRAM_LAT_MIN = 1;
  localparam int SRAM_LAT_MAX = 2;

  // BWEB polarity: a 0 in the mask selects the new bit, a 1 keeps the stored bit.
  function automatic logic sram_mask_bit(input logic old_bit, input logic new_bit,
                                         input logic mask_bit);
    return (old_bit & mask_bit) | (new_bit & ~mask_bit);
  endfunction

  function automatic bit sram_params_ok(input int read_latency, input int word_depth,
                                        input int add_width);
    return (read_latency >= SRAM_LAT_MIN) && (read_latency <= SRAM_LAT_MAX) &&
           (add_width >= 1) && (add_width <= 31) && (word_depth >= 1) &&
           (longint'(word_depth) <= (longint'(1) << add_width));
  endfunction

endpackage

// File: rtl/sram_1r1w_model_if.sv
// Port bundle of the two-port SRAM model: read request, write request and read response.
// The macro is the slave; whatever issues requests is the master.
interface sram_1r1w_model_if #(
  parameter int Bits      = 80,
  parameter int Add_Width = 8
);
  logic                 CEBA;
  logic [Add_Width-1:0] AA;
  logic                 CEBB;
  logic [Add_Width-1:0] AB;
  logic [Bits-1:0]      DB;
  logic [Bits-1:0]      BWEB;
  logic [Bits-1:0]      QA;
  logic                 COLL;

  modport master (
    output CEBA, AA, CEBB, AB, DB, BWEB,
    input  QA, COLL
  );

  modport slave (
    input  CEBA, AA, CEBB, AB, DB, BWEB,
    output QA, COLL
  );
endinterface

// File: rtl/sram_rd_pipe.sv
// Read-data pipeline of the SRAM model: Read_Latency register stages ending in the QA/COLL registers.
// SRAM_MODEL_RANDOM_OUT_EN makes QA take random data on cycles that deliver no read.
module sram_rd_pipe #(
  parameter int Bits         = 80,
  parameter int Read_Latency = 1
) (
  input  logic            CLK,
  input  logic            RSTB,
  input  logic            i_rd_vld,
  input  logic [Bits-1:0] i_rd_data,
  input  logic            i_rd_coll,
  output logic [Bits-1:0] o_qa,
  output logic            o_coll
);

  localparam int LAST = Read_Latency - 1;

  // Element 0 is the raw request; element k is the request delayed by k edges.
  logic            w_stg_vld  [Read_Latency];
  logic [Bits-1:0] w_stg_data [Read_Latency];
  logic            w_stg_coll [Read_Latency];

  logic [Bits-1:0] r_qa;
  logic            r_coll;

  assign w_stg_vld[0]  = i_rd_vld;
  assign w_stg_data[0] = i_rd_data;
  assign w_stg_coll[0] = i_rd_coll;

  genvar gi;
  generate
    for (gi = 1; gi < Read_Latency; gi++) begin : g_stage
      logic            r_vld;
      logic [Bits-1:0] r_data;
      logic            r_coll_stg;

      always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
          r_vld      <= 1'b0;
          r_data     <= '0;
          r_coll_stg <= 1'b0;
        end else begin
          r_vld      <= w_stg_vld[gi-1];
          r_data     <= w_stg_data[gi-1];
          r_coll_stg <= w_stg_vld[gi-1] & w_stg_coll[gi-1];
        end
      end

      assign w_stg_vld[gi]  = r_vld;
      assign w_stg_data[gi] = r_data;
      assign w_stg_coll[gi] = r_coll_stg;
    end
  endgenerate

`ifdef SRAM_MODEL_RANDOM_OUT_EN
  localparam int RAND_WORDS = (Bits + 31) / 32;

  function automatic logic [Bits-1:0] rand_word();
    logic [RAND_WORDS*32-1:0] w_acc;
    for (int k = 0; k < RAND_WORDS; k++) begin
      w_acc[k*32 +: 32] = $random;
    end
    return w_acc[Bits-1:0];
  endfunction
`endif

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      r_qa   <= '0;
      r_coll <= 1'b0;
    end else begin
      r_coll <= w_stg_vld[LAST] & w_stg_coll[LAST];
      if (w_stg_vld[LAST]) begin
        r_qa <= w_stg_data[LAST];
      end
`ifdef SRAM_MODEL_RANDOM_OUT_EN
      else begin
        r_qa <= rand_word();
      end
`endif
    end
  end

  assign o_qa   = r_qa;
  assign o_coll = r_coll;

endmodule

// File: rtl/sram_1r1w_model.sv
// Two-port (1R/1W) SRAM macro model: storage array, bit-masked writes, read-before-write collisions.
// Optional macro SRAM_MODEL_RANDOM_OUT_EN: QA is randomised on non-read cycles (see sram_rd_pipe).
module sram_1r1w_model
  import sram_model_pkg::*;
#(
  parameter int Bits         = 80,
  parameter int Word_Depth   = 256,
  parameter int Add_Width    = 8,
  parameter int Read_Latency = 1
) (
  input logic               CLK,
  input logic               RSTB,
  sram_1r1w_model_if.slave  bus
);

  if (!sram_params_ok(Read_Latency, Word_Depth, Add_Width)) begin : g_param_err
    $fatal(1, "sram_1r1w_model: illegal parameters Read_Latency=%0d Word_Depth=%0d Add_Width=%0d",
           Read_Latency, Word_Depth, Add_Width);
  end

  localparam int          IDX_W   = (Word_Depth > 1) ? $clog2(Word_Depth) : 1;
  localparam logic [31:0] DEPTH_U = 32'(Word_Depth);

  // Contents are deliberately never reset, matching the silicon macro.
  logic [Bits-1:0] r_mem [Word_Depth];

  logic             w_rd_en;
  logic             w_wr_en;
  logic             w_coll;
  logic [IDX_W-1:0] w_rd_idx;
  logic [IDX_W-1:0] w_wr_idx;
  logic [Bits-1:0]  w_rd_word;
  logic [Bits-1:0]  w_wr_old;
  logic [Bits-1:0]  w_wr_word;

  assign w_rd_en  = !bus.CEBA && (32'(bus.AA) < DEPTH_U);
  assign w_wr_en  = !bus.CEBB && (32'(bus.AB) < DEPTH_U);
  assign w_rd_idx = bus.AA[IDX_W-1:0];
  assign w_wr_idx = bus.AB[IDX_W-1:0];

  // The array read here sees the value before this edge's write lands, giving read-before-write.
  assign w_rd_word = w_rd_en ? r_mem[w_rd_idx] : '0;
  assign w_coll    = w_rd_en && !bus.CEBB && (bus.AA == bus.AB);
  assign w_wr_old  = r_mem[w_wr_idx];

  genvar gi;
  generate
    for (gi = 0; gi < Bits; gi++) begin : g_wmask
      assign w_wr_word[gi] = sram_mask_bit(w_wr_old[gi], bus.DB[gi], bus.BWEB[gi]);
    end
  endgenerate

  // Writes proceed regardless of RSTB; reset only touches the output path.
  always_ff @(posedge CLK) begin
    if (w_wr_en) begin
      r_mem[w_wr_idx] <= w_wr_word;
    end
  end

  sram_rd_pipe #(
    .Bits         (Bits),
    .Read_Latency (Read_Latency)
  ) u_rd_pipe (
    .CLK       (CLK),
    .RSTB      (RSTB),
    .i_rd_vld  (w_rd_en),
    .i_rd_data (w_rd_word),
    .i_rd_coll (w_coll),
    .o_qa      (bus.QA),
    .o_coll    (bus.COLL)
  );

endmodule
